data_memory_mmio: RTL and testbench

- Data-side memory stage directly downstream of the 12-bit single-cycle ARM core.
- Consumes the core's MemoryWrite, ALUResult (used as the address), and WriteData; returns ReadData.
- Contains a word-addressed data RAM plus a memory-mapped block: GPIO output and input registers, and a 12-bit prescaled timer with compare and interrupt.
- Reads are combinational so the single-cycle core gets ReadData in the same cycle; every write and all state update on the rising clock edge.

---
 rtl/mem_map_pkg.sv | 17 +
 rtl/mmio_timer.sv | 83 ++++++++
 rtl/data_memory_mmio.sv | 74 +++++++
 tb/tb_data_memory_mmio.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared address map, TCTRL bit positions and word type for the data-side memory stage.
package mem_map_pkg;

    typedef logic [11:0] word_t;

    localparam word_t ADDR_GPIO_OUT = 12'hF00;
    localparam word_t ADDR_GPIO_IN  = 12'hF01;
    localparam word_t ADDR_TCOUNT   = 12'hF02;
    localparam word_t ADDR_TCMP     = 12'hF03;
    localparam word_t ADDR_TCTRL    = 12'hF04;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AR   = 1;
    localparam int TCTRL_FLAG = 2;
    localparam int TCTRL_IE   = 3;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled 12-bit timer with compare flag and level interrupt, MMIO register port.
// Latency: register reads combinational, writes and counting take effect on the next edge.
// Backpressure: none; accepts a write every cycle.
module mmio_timer
    import mem_map_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [11:0] addr,
    input  logic [11:0] wdata,
    output logic [11:0] rdata,
    output logic        irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc;
    word_t         tcount;
    word_t         tcmp;
    logic          en, ar, flag, ie;

    logic wr_count, wr_cmp, wr_ctrl;
    logic tick, match, flag_nxt, ie_nxt;

    assign wr_count = wr_en && (addr == ADDR_TCOUNT);
    assign wr_cmp   = wr_en && (addr == ADDR_TCMP);
    assign wr_ctrl  = wr_en && (addr == ADDR_TCTRL);

    assign tick  = en && (presc == PW'(PRESCALE - 1));
    assign match = tick && (tcount == tcmp);

    // A match sets FLAG even when software clears it in the same cycle.
    assign flag_nxt = match | (flag & ~(wr_ctrl & wdata[TCTRL_FLAG]));
    assign ie_nxt   = wr_ctrl ? wdata[TCTRL_IE] : ie;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc  <= '0;
            tcount <= '0;
            tcmp   <= '0;
            en     <= 1'b0;
            ar     <= 1'b0;
            flag   <= 1'b0;
            ie     <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (!en || wr_count || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            if (wr_count)
                tcount <= wdata;
            else if (tick)
                tcount <= (match && ar) ? 12'h000 : tcount + 12'h001;

            if (wr_cmp)
                tcmp <= wdata;

            if (wr_ctrl) begin
                en <= wdata[TCTRL_EN];
                ar <= wdata[TCTRL_AR];
            end
            ie   <= ie_nxt;
            flag <= flag_nxt;
            irq  <= flag_nxt & ie_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_TCOUNT: rdata = tcount;
            ADDR_TCMP:   rdata = tcmp;
            ADDR_TCTRL:  rdata = {8'h00, ie, flag, ar, en};
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory stage: word RAM, GPIO out/in registers and timer behind one address decode.
// Latency: ReadData combinational from Address; writes land on the rising edge.
// Backpressure: none; the core may load or store every cycle.
module data_memory_mmio
    import mem_map_pkg::*;
#(
    parameter int RAM_DEPTH = 256,
    parameter int PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemoryWrite,
    input  logic [11:0] Address,
    input  logic [11:0] WriteData,
    output logic [11:0] ReadData,
    input  logic [11:0] gpio_in,
    output logic [11:0] gpio_out,
    output logic        timer_irq
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    word_t ram [RAM_DEPTH];
    word_t gpio_s1, gpio_s2;
    word_t timer_rdata;
    logic  in_ram;

    assign in_ram = (Address < 12'(RAM_DEPTH));

    always_ff @(posedge clk) begin
        if (MemoryWrite && in_ram)
            ram[Address[AW-1:0]] <= WriteData;
    end

    // gpio_in is asynchronous; software only ever sees the second flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            if (MemoryWrite && (Address == ADDR_GPIO_OUT))
                gpio_out <= WriteData;
        end
    end

    mmio_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .wr_en (MemoryWrite),
        .addr  (Address),
        .wdata (WriteData),
        .rdata (timer_rdata),
        .irq   (timer_irq)
    );

    always_comb begin
        ReadData = '0;
        if (in_ram) begin
            ReadData = ram[Address[AW-1:0]];
        end else begin
            case (Address)
                ADDR_GPIO_OUT: ReadData = gpio_out;
                ADDR_GPIO_IN:  ReadData = gpio_s2;
                default:       ReadData = timer_rdata;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;

    logic        clk;
    logic        reset;
    logic        MemoryWrite;
    logic [11:0] Address;
    logic [11:0] WriteData;
    logic [11:0] ReadData;
    logic [11:0] gpio_in;
    logic [11:0] gpio_out;
    logic        timer_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: kind 0 = ReadData, 1 = gpio_out, 2 = timer_irq
    int          q_kind [$];
    logic [11:0] q_exp  [$];
    string       q_name [$];

    data_memory_mmio #(.RAM_DEPTH(256), .PRESCALE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemoryWrite (MemoryWrite),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .timer_irq   (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drains everything expected for the current cycle at the falling edge.
    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            int          k;
            logic [11:0] e;
            logic [11:0] got;
            string       nm;
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            case (k)
                0:       got = ReadData;
                1:       got = gpio_out;
                default: got = {11'h000, timer_irq};
            endcase
            n_cmp = n_cmp + 1;
            if (got !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %03h expected %03h", nm, got, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input int k, input logic [11:0] e, input string nm);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [11:0] a, input logic [11:0] d);
        MemoryWrite = w;
        Address     = a;
        WriteData   = d;
    endtask

    task automatic wr(input logic [11:0] a, input logic [11:0] d);
        drive(1'b1, a, d);
        tick();
        drive(1'b0, 12'h000, 12'h000);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [11:0] e, input string nm);
        drive(1'b0, a, 12'h000);
        push(0, e, nm);
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        gpio_in = 12'h000;
        drive(1'b0, 12'h000, 12'h000);
        tick();
        tick();
        reset = 1'b1;

        n_cmp = n_cmp + 1;
        if (gpio_out !== 12'h000) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_gpio_out: got %03h expected 000", gpio_out);
        end
        n_cmp = n_cmp + 1;
        if (timer_irq !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_rst_irq: got %0b expected 0", timer_irq);
        end

        // Reset state
        push(1, 12'h000, "rst_gpio_out");
        push(2, 12'h000, "rst_irq");
        rd_chk(12'hF02, 12'h000, "rst_tcount");
        rd_chk(12'hF03, 12'h000, "rst_tcmp");
        rd_chk(12'hF04, 12'h000, "rst_tctrl");
        rd_chk(12'hF01, 12'h000, "rst_gpio_in");

        // RAM, read-during-write, range boundaries and aliasing
        wr(12'h010, 12'h111);
        drive(1'b1, 12'h010, 12'hABC);
        push(0, 12'h111, "ram_rdw_old");
        tick();
        rd_chk(12'h010, 12'hABC, "ram_rd_new");
        wr(12'h000, 12'h0AA);
        wr(12'h0FF, 12'h321);
        wr(12'h100, 12'h555);
        wr(12'h500, 12'h777);
        rd_chk(12'h0FF, 12'h321, "ram_top");
        rd_chk(12'h100, 12'h000, "oob_100");
        rd_chk(12'h500, 12'h000, "unmapped_500");
        rd_chk(12'h000, 12'h0AA, "no_alias");
        rd_chk(12'hF05, 12'h000, "unmapped_f05");

        // GPIO
        gpio_in = 12'h5A5;
        rd_chk(12'hF01, 12'h000, "gpi_edge0");
        rd_chk(12'hF01, 12'h000, "gpi_edge1");
        rd_chk(12'hF01, 12'h5A5, "gpi_edge2");
        drive(1'b1, 12'hF00, 12'h3C3);
        push(1, 12'h000, "gpo_before");
        tick();
        n_cmp = n_cmp + 1;
        if (gpio_out !== 12'h3C3) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_gpo_after: got %03h expected 3c3", gpio_out);
        end
        push(1, 12'h3C3, "gpo_after");
        rd_chk(12'hF00, 12'h3C3, "gpo_read");

        // Timer with autoreload and interrupt
        wr(12'hF03, 12'h003);
        wr(12'hF04, 12'h00B);
        for (int k = 0; k <= 16; k++) begin
            logic [11:0] e;
            e = (k < 4) ? 12'h000 : (k < 8) ? 12'h001 : (k < 12) ? 12'h002 :
                (k < 16) ? 12'h003 : 12'h000;
            push(2, (k >= 16) ? 12'h001 : 12'h000, $sformatf("irq_k%0d", k));
            rd_chk(12'hF02, e, $sformatf("tcount_k%0d", k));
        end
        rd_chk(12'hF04, 12'h00F, "flag_set");
        drive(1'b1, 12'hF04, 12'h00F);
        push(2, 12'h001, "irq_before_clr");
        tick();
        push(2, 12'h000, "irq_cleared");
        rd_chk(12'hF04, 12'h00B, "flag_cleared");
        repeat (10) tick();
        rd_chk(12'hF02, 12'h003, "pre_match");
        wr(12'hF04, 12'h00F);
        push(2, 12'h001, "irq_set_wins");
        rd_chk(12'hF04, 12'h00F, "set_wins");
        rd_chk(12'hF02, 12'h000, "reload_again");
        wr(12'hF04, 12'h000);
        push(2, 12'h000, "irq_ie_off");
        rd_chk(12'hF04, 12'h004, "flag_kept");
        wr(12'hF04, 12'h004);
        rd_chk(12'hF04, 12'h000, "flag_clr2");

        // Wrap without match, then a TCOUNT write on a tick cycle
        wr(12'hF03, 12'h100);
        wr(12'hF02, 12'hFFE);
        wr(12'hF04, 12'h001);
        for (int k = 0; k <= 8; k++) begin
            logic [11:0] e;
            e = (k < 4) ? 12'hFFE : (k < 8) ? 12'hFFF : 12'h000;
            rd_chk(12'hF02, e, $sformatf("wrap_k%0d", k));
        end
        rd_chk(12'hF04, 12'h001, "wrap_noflag");
        tick();
        wr(12'hF02, 12'h050);
        for (int k = 12; k <= 16; k++) begin
            rd_chk(12'hF02, (k < 16) ? 12'h050 : 12'h051, $sformatf("load_k%0d", k));
        end

        // Reset mid-count
        wr(12'hF00, 12'h0FF);
        wr(12'hF02, 12'h123);
        rd_chk(12'hF02, 12'h123, "pre_rst_tcount");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp = n_cmp + 1;
        if (gpio_out !== 12'h000) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_mid_rst_gpo: got %03h expected 000", gpio_out);
        end
        n_cmp = n_cmp + 1;
        if (timer_irq !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL direct_mid_rst_irq: got %0b expected 0", timer_irq);
        end
        push(1, 12'h000, "mid_rst_gpo");
        push(2, 12'h000, "mid_rst_irq");
        rd_chk(12'hF02, 12'h000, "mid_rst_tcount");
        rd_chk(12'hF04, 12'h000, "mid_rst_tctrl");
        rd_chk(12'hF03, 12'h000, "mid_rst_tcmp");
        rd_chk(12'h010, 12'hABC, "ram_survives");
        repeat (6) tick();
        rd_chk(12'hF02, 12'h000, "stays_disabled");
        wr(12'hF04, 12'h001);
        for (int k = 0; k <= 4; k++) begin
            rd_chk(12'hF02, (k < 4) ? 12'h000 : 12'h001, $sformatf("restart_k%0d", k));
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
